// File: rtl/cell_redraw_queue_if.sv
// cell_redraw_queue_if
// Groups the tracker-side scan stream, the display-writer command handshake
// and the queue status lines into one bundle.
//   in_valid/in_diff/in_x/in_y/in_obj_code : per-cell scan stream from the tracker
//   out_valid/out_ready                    : command handshake to the display writer
//   out_x0/out_y0/out_x1/out_y1/out_color  : rectangle-fill command payload
//   level/overflow                         : FIFO occupancy and sticky drop flag
// slave  : the queue's view (consumes scan stream, produces commands)
// master : the surrounding system's view (tracker + display writer)
interface cell_redraw_queue_if;
    logic        in_valid;
    logic        in_diff;
    logic [3:0]  in_x;
    logic [3:0]  in_y;
    logic [2:0]  in_obj_code;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_x0;
    logic [8:0]  out_y0;
    logic [8:0]  out_x1;
    logic [8:0]  out_y1;
    logic [15:0] out_color;
    logic [4:0]  level;
    logic        overflow;

    modport slave (
        input  in_valid, in_diff, in_x, in_y, in_obj_code, out_ready,
        output out_valid, out_x0, out_y0, out_x1, out_y1, out_color, level, overflow
    );

    modport master (
        output in_valid, in_diff, in_x, in_y, in_obj_code, out_ready,
        input  out_valid, out_x0, out_y0, out_x1, out_y1, out_color, level, overflow
    );
endinterface

// File: rtl/cell_redraw_queue.sv
// cell_redraw_queue
// Buffers changed cells from the frame tracker in a FIFO and issues one
// registered rectangle-fill command (pixel bounds + RGB565 colour) per cell
// to the display writer over a valid/ready handshake.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : cell_redraw_queue_if.slave (scan stream in, commands out, status)
module cell_redraw_queue #(
    parameter int DEPTH   = 16,
    parameter int CELL_PX = 16
) (
    input logic                  clk,
    input logic                  rst,
    cell_redraw_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SH = $clog2(CELL_PX);

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [2:0] code;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [4:0]      count;

    logic            out_valid;
    logic [8:0]      out_x0, out_y0, out_x1, out_y1;
    logic [15:0]     out_color;
    logic            overflow;

    logic            push, load, accept;
    entry_t          head;
    logic [8:0]      nx_x0, nx_y0;

    function automatic logic [15:0] color_of(input logic [2:0] code);
        case (code)
            3'b000:  return 16'h0000;
            3'b001:  return 16'h07E0;
            3'b010:  return 16'h03E0;
            3'b011:  return 16'hF800;
            3'b100:  return 16'hFFFF;
            default: return 16'hF81F;
        endcase
    endfunction

    assign push = bus.in_valid & bus.in_diff;
    assign load = (count != 5'd0) & (~out_valid | bus.out_ready);
    // A full FIFO still accepts when the head leaves at the same edge; the
    // write lands in the slot being vacated, read before it is overwritten.
    assign accept = push & ((count < 5'(DEPTH)) | load);

    assign head  = mem[rd_ptr];
    assign nx_x0 = 9'(head.x) << SH;
    assign nx_y0 = 9'(head.y) << SH;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= entry_t'{bus.in_x, bus.in_y, bus.in_obj_code};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_x0    <= '0;
            out_y0    <= '0;
            out_x1    <= '0;
            out_y1    <= '0;
            out_color <= '0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (push & ~accept) begin
                overflow <= 1'b1;
            end
            if (accept & ~load) begin
                count <= count + 5'd1;
            end else if (load & ~accept) begin
                count <= count - 5'd1;
            end

            if (load) begin
                rd_ptr    <= rd_ptr + AW'(1);
                out_valid <= 1'b1;
                out_x0    <= nx_x0;
                out_y0    <= nx_y0;
                out_x1    <= nx_x0 + 9'(CELL_PX - 1);
                out_y1    <= nx_y0 + 9'(CELL_PX - 1);
                out_color <= color_of(head.code);
            end else if (out_valid & bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_x0    = out_x0;
    assign bus.out_y0    = out_y0;
    assign bus.out_x1    = out_x1;
    assign bus.out_y1    = out_y1;
    assign bus.out_color = out_color;
    assign bus.level     = count;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_cell_redraw_queue.sv
// tb_cell_redraw_queue
// Drives cell_redraw_queue through directed scenarios and a random phase,
// comparing every output each cycle with a queue-based reference model.
module tb_cell_redraw_queue;
    localparam int DEPTH   = 16;
    localparam int CELL_PX = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cell_redraw_queue_if bus ();

    cell_redraw_queue #(.DEPTH(DEPTH), .CELL_PX(CELL_PX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int x;
        int y;
        int code;
    } cell_t;

    cell_t       q[$];
    bit          m_valid;
    int          m_x0, m_y0, m_x1, m_y1, m_color;
    bit          m_ovf;
    int          n_cmp = 0;
    int          n_err = 0;
    int          dut_acc;
    int          palette [8] = '{'h0000, 'h07E0, 'h03E0, 'hF800, 'hFFFF, 'hF81F, 'hF81F, 'hF81F};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int  lvl;
        bit  ld, ps, acc;
        cell_t e;
        if (rst) begin
            q.delete();
            m_valid = 0; m_ovf = 0;
            m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0; m_color = 0;
            return;
        end
        lvl = q.size();
        ld  = (lvl != 0) && (!m_valid || bus.out_ready);
        ps  = bus.in_valid && bus.in_diff;
        acc = ps && (lvl < DEPTH || ld);
        if (ld) begin
            e       = q.pop_front();
            m_x0    = e.x * CELL_PX;
            m_y0    = e.y * CELL_PX;
            m_x1    = m_x0 + CELL_PX - 1;
            m_y1    = m_y0 + CELL_PX - 1;
            m_color = palette[e.code];
            m_valid = 1;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 0;
        end
        if (acc) begin
            e.x = int'(bus.in_x); e.y = int'(bus.in_y); e.code = int'(bus.in_obj_code);
            q.push_back(e);
        end else if (ps) begin
            m_ovf = 1;
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("level",     32'(bus.level),     32'(q.size()));
        chk("overflow",  32'(bus.overflow),  32'(m_ovf));
        chk("out_x0",    32'(bus.out_x0),    32'(m_x0));
        chk("out_y0",    32'(bus.out_y0),    32'(m_y0));
        chk("out_x1",    32'(bus.out_x1),    32'(m_x1));
        chk("out_y1",    32'(bus.out_y1),    32'(m_y1));
        chk("out_color", 32'(bus.out_color), 32'(m_color));
    endtask

    task automatic step();
        if (bus.out_valid && bus.out_ready && !rst) dut_acc++;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input bit d, input int x, input int y, input int c);
        bus.in_valid    = v;
        bus.in_diff     = d;
        bus.in_x        = 4'(x);
        bus.in_y        = 4'(y);
        bus.in_obj_code = 3'(c);
    endtask

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;

        // idle scan stream with no changes
        drive(1, 0, 5, 5, 3);
        for (int i = 0; i < 20; i++) step();
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_color", 32'(bus.out_color), 32'd0);

        // single push, first-command latency
        drive(1, 1, 4, 3, 1);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_x0", 32'(bus.out_x0), 32'd64);
        chk("single_y0", 32'(bus.out_y0), 32'd48);
        chk("single_x1", 32'(bus.out_x1), 32'd79);
        chk("single_y1", 32'(bus.out_y1), 32'd63);
        chk("single_color", 32'(bus.out_color), 32'h07E0);
        step();
        chk("single_drop_valid", 32'(bus.out_valid), 32'd0);

        // backpressure hold then consecutive drain
        bus.out_ready = 1'b0;
        drive(1, 1, 1, 1, 3); step();
        drive(1, 1, 2, 2, 2); step();
        drive(1, 1, 3, 3, 4); step();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step();
        chk("hold_level", 32'(bus.level), 32'd2);
        chk("hold_color", 32'(bus.out_color), 32'hF800);
        bus.out_ready = 1'b1;
        step();
        chk("drain_color1", 32'(bus.out_color), 32'h03E0);
        step();
        chk("drain_color2", 32'(bus.out_color), 32'hFFFF);
        step();
        step();

        // overflow: DEPTH+2 pushes with backpressure
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(1, 1, i % 16, i % 12, i % 8);
            step();
        end
        drive(0, 0, 0, 0, 0);
        step();
        chk("ovf_level", 32'(bus.level), 32'd16);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);

        // full queue, simultaneous load and push
        bus.out_ready = 1'b1;
        dut_acc = 0;
        drive(1, 1, 15, 11, 7);
        step();
        chk("full_push_level", 32'(bus.level), 32'd16);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH + 4; i++) step();
        chk("drain_count", 32'(dut_acc), 32'd18);
        chk("last_x1", 32'(bus.out_x1), 32'd255);
        chk("last_y1", 32'(bus.out_y1), 32'd191);
        chk("last_color", 32'(bus.out_color), 32'hF81F);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        // reset with queued entries and a pending command
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, i, i, i);
            step();
        end
        drive(0, 0, 0, 0, 0);
        chk("pre_rst_level", 32'(bus.level), 32'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        bus.out_ready = 1'b1;
        drive(1, 1, 2, 9, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_y0", 32'(bus.out_y0), 32'd144);

        // random phase
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0) ^ (i >= 300 && i < 400);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cell_redraw_queue.md
Name: cell_redraw_queue

Overview:
- Sits directly downstream of the frame tracker.
- Consumes the tracker's per-cell scan stream (x, y, obj_code, diff) and buffers only the changed cells in a FIFO.
- Emits one registered rectangle-fill command per changed cell (pixel bounds plus RGB565 colour) to the display writer over a valid/ready handshake.
- The tracker has no backpressure, so the queue absorbs bursts and flags overflow.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
CELL_PX, 16, cell edge length in pixels; power of two

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  tracker has a valid cell on in_x/in_y/in_obj_code/in_diff this cycle
in_diff  input  1  cell differs from previous frame
in_x  input  4  cell column, 0..15
in_y  input  4  cell row, 0..11
in_obj_code  input  3  cell contents: 000 empty, 001 head, 010 body, 011 apple, 100 border
out_valid  output  1  command registers hold a valid command
out_ready  input  1  display writer accepts the command
out_x0  output  9  left pixel = in_x*CELL_PX
out_y0  output  9  top pixel = in_y*CELL_PX
out_x1  output  9  right pixel = out_x0+CELL_PX-1
out_y1  output  9  bottom pixel = out_y0+CELL_PX-1
out_color  output  16  RGB565 fill colour
level  output  5  FIFO occupancy, 0..DEPTH; excludes the output register
overflow  output  1  sticky; a push was dropped

Behaviour:
- Reset (rst high at a clock edge):
  - FIFO pointers and level go to 0; out_valid, overflow go to 0.
  - out_x0, out_y0, out_x1, out_y1, out_color go to 0.
  - rst overrides all other inputs in that cycle; reset mid-transfer discards everything, including an unaccepted command.
- Push:
  - push = in_valid & in_diff.
  - The entry {x, y, obj_code} is written at the edge where push is high and space exists.
  - in_valid=0 or in_diff=0 never writes.
- Load (FIFO to output registers): load = (level != 0) & (!out_valid | out_ready).
  - At that edge the head entry is popped and translated into the output registers; out_valid goes to 1.
  - If out_valid & out_ready and level==0, out_valid goes to 0 at that edge.
  - While out_valid & !out_ready, all out_* fields hold stable.
- Latency:
  - Push at edge N into an empty queue with an idle output gives out_valid=1 after edge N+1.
  - Back-to-back commands are issued one per cycle while out_ready=1.
- Order: strict FIFO; commands leave in push order.
- Space rule: a push is accepted if level<DEPTH, or if level==DEPTH and a load occurs at the same edge.
  - Otherwise the entry is dropped, overflow is set to 1 and held until reset, and level is unchanged.
- level arithmetic:
  - push accepted and load in the same cycle: level unchanged.
  - push only: level+1.
  - load only: level-1.
  - Pointers wrap modulo DEPTH.
- Coordinate math: zero-extend to 9 bits, then shift left by log2(CELL_PX). Maximums at CELL_PX=16: x1=255, y1=191; no overflow.
- Colour map, applied at load:
  - 000 -> 0x0000
  - 001 -> 0x07E0
  - 010 -> 0x03E0
  - 011 -> 0xF800
  - 100 -> 0xFFFF
  - 101/110/111 -> 0xF81F (error magenta)
- Out-of-range coordinates (x>15 impossible; y>11) pass through unchecked.

Test Plan:
- Reset, then idle 20 cycles with in_valid=1, in_diff=0 -> out_valid=0, level=0, overflow=0, all out_* = 0.
- Single push x=4,y=3,code=001 at edge N, out_ready=1 -> out_valid=1 after N+1 with x0=64, y0=48, x1=79, y1=63, color=0x07E0; out_valid=0 one cycle later.
- out_ready=0, push 3 cells (code 011, 010, 100) -> first command held stable for 10 cycles and level=2; raise out_ready -> colours 0xF800, 0x03E0, 0xFFFF on consecutive cycles.
- out_ready=0, push DEPTH+2=18 cells -> level=16 and overflow=1; release out_ready -> exactly 17 commands (1 registered + 16 queued) in push order, overflow stays 1.
- level=16, out_valid=1, out_ready=1, push x=15,y=11,code=111 in the same cycle -> push accepted, level stays 16, last command x1=255, y1=191, color=0xF81F.
- Queue holding 5 entries with out_valid=1, assert rst for one cycle -> next cycle out_valid=0, level=0, overflow=0; a new push then emits normally after 2 edges.
